fuzz_mem_model: RTL and testbench
=================================

FUZZ_MEM_MODEL -- requirements
Module: fuzz_mem_model

Interface
REQ-001 Parameter ADDR_W, 32, byte-address width.
REQ-002 Parameter DATA_W, 32, data width; multiple of 8.
REQ-003 Parameter DEPTH_WORDS, 4096, number of words in the backing array.
REQ-004 Parameter INSTR_LIMIT, 32'h0000_FFFF, last byte address of the instruction region; higher addresses are the data region.
REQ-005 Parameter LATENCY, 1, wait cycles from request accept to mem_ready; legal range 1..15.
REQ-006 Parameter INSTR_FILL, 32'h0000_0013, fill word for unwritten instruction-region words.
REQ-007 Parameter LFSR_SEED, 32'hACE1_2468, non-zero seed for the data-fill LFSR.
REQ-008 Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, synchronous, active-high.
- mem_valid, input, 1: request valid.
- mem_instr, input, 1: instruction fetch qualifier; trace only.
- mem_addr, input, ADDR_W: byte address.
- mem_wdata, input, DATA_W: write data.
- mem_wstrb, input, DATA_W/8: byte enables; all zero means read.
- mem_ready, output, 1: one-cycle response strobe.
- mem_rdata, output, DATA_W: read data, valid while mem_ready=1.
- fill_valid, output, 1: one-cycle pulse when an unwritten word is materialised.
- fill_addr, output, ADDR_W-2: word index of the fill.
- fill_data, output, DATA_W: value materialised.
- err_oob, output, 1: one-cycle pulse on an out-of-range access.

Function
REQ-009 FSM states IDLE, WAIT, RESP; IDLE->WAIT when mem_valid=1, latching addr, wdata, wstrb and instr; wait counter loaded with wait count minus 1.
REQ-010 WAIT decrements the counter each cycle; WAIT->RESP when the counter is 0.
REQ-011 RESP performs the access, drives mem_ready=1 for exactly one cycle, then goes to IDLE; mem_valid is ignored outside IDLE.
REQ-012 Word index is addr[ADDR_W-1:2]; addr[1:0] is ignored; index >= DEPTH_WORDS is out of range: err_oob pulses in RESP, mem_rdata=0, no write, no fill.
REQ-013 Each word has a written bit; a read of an unwritten word materialises INSTR_FILL (addr <= INSTR_LIMIT) or the current data-LFSR value (addr > INSTR_LIMIT), stores it, sets the written bit, and pulses fill_valid with fill_addr and fill_data in RESP.
REQ-014 A write to an unwritten word first materialises the fill value per REQ-013 (fill_valid pulses), then merges the strobed bytes.
REQ-015 Write merges only bytes with mem_wstrb[i]=1; mem_rdata=0 on writes.
REQ-016 A read returns the current stored value including prior writes (read-after-write coherent).
REQ-017 Data LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1; advances only on a data-region fill; DATA_W>32 replicates the LFSR word.
REQ-018 Latency: a request accepted at edge N gives mem_ready=1 in the cycle following edge N+wait count.

Reset
REQ-019 rst=1 forces IDLE, mem_ready=0, mem_rdata=0, fill_valid=0, fill_addr=0, fill_data=0, err_oob=0, all written bits cleared, LFSRs reloaded with their seeds.
REQ-020 rst during WAIT or RESP aborts the access: no write committed, no fill, no mem_ready.

Configuration
REQ-021 Macro FUZZ_MEM_RAND_WAIT_EN defined: wait count = LATENCY + wait-LFSR[1:0] (second LFSR, seed ~LFSR_SEED, advances once per accepted request); undefined: wait count = LATENCY exactly.

Structure
REQ-022 Package fuzz_mem_pkg holds the FSM state enum, LFSR tap constant, default INSTR_FILL and default seed.
REQ-023 Sub-module fuzz_mem_lfsr (width, seed, enable, synchronous reset) is instantiated for the data LFSR and, under the macro, the wait LFSR.

Verification
REQ-024 Read addr 0x0000_0010 after reset, LATENCY=1 -> mem_ready 2 cycles after mem_valid, mem_rdata=0x0000_0013, fill_valid=1, fill_addr=4.
REQ-025 Read 0x0001_0000 twice -> first read fill_data equals the first LFSR output, second read returns same value with fill_valid=0.
REQ-026 Write 0x0001_0004, wdata 0xDEADBEEF, wstrb 4'b0101, then read -> bytes 0 and 2 are 0xEF and 0xAD, bytes 1 and 3 are from the fill value.
REQ-027 Access addr 4*DEPTH_WORDS -> err_oob=1 with mem_ready, mem_rdata=0, subsequent read of word 0 unaffected.
REQ-028 rst asserted during WAIT of a write to 0x0000_0020 -> no mem_ready; later read of 0x0000_0020 returns 0x0000_0013 with fill_valid=1.
REQ-029 FUZZ_MEM_RAND_WAIT_EN defined, LATENCY=2, 100 reads -> every latency in 2..5 and matches the reference LFSR model cycle-for-cycle.

Source files
------------

// File: rtl/fuzz_mem_pkg.sv
// Shared types and constants for the fuzzing memory model.
package fuzz_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;
    localparam logic [31:0] DEF_INSTR_FILL = 32'h0000_0013;
    localparam logic [31:0] DEF_LFSR_SEED  = 32'hACE1_2468;

endpackage

// File: rtl/fuzz_mem_lfsr.sv
// Galois LFSR with synchronous reload of its seed and an advance enable.
module fuzz_mem_lfsr
    import fuzz_mem_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_LFSR_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    // Shift toward bit 0 and fold the outgoing bit into the tap positions
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (en) begin
            q <= (q >> 1) ^ (q[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/fuzz_mem_model.sv
// Lazily-filled memory model for fuzzing a simple valid/ready memory port.
// Unwritten words are materialised on first touch: instruction region with
// INSTR_FILL, data region with a pseudo-random LFSR word.
// Optional macro FUZZ_MEM_RAND_WAIT_EN adds 0..3 random wait cycles per request.
//
// state | meaning
// IDLE  | waiting for mem_valid; request fields captured on accept
// WAIT  | counting down the wait cycles
// RESP  | access performed, mem_ready pulses for this one cycle
module fuzz_mem_model
    import fuzz_mem_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH_WORDS = 4096,
    parameter logic [ADDR_W-1:0] INSTR_LIMIT = ADDR_W'(32'h0000_FFFF),
    parameter int                LATENCY     = 1,
    parameter logic [DATA_W-1:0] INSTR_FILL  = DATA_W'(DEF_INSTR_FILL),
    parameter logic [31:0]       LFSR_SEED   = DEF_LFSR_SEED
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_valid,
    input  logic                mem_instr,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_ready,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                fill_valid,
    output logic [ADDR_W-3:0]   fill_addr,
    output logic [DATA_W-1:0]   fill_data,
    output logic                err_oob
);

    localparam int          STRB_W  = DATA_W / 8;
    localparam int          IDX_W   = ADDR_W - 2;
    localparam int          MEM_AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          CNT_W   = 5;
    localparam logic [63:0] DEPTH_L = 64'(DEPTH_WORDS);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    wait_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                instr_q;
    logic                accept;

    logic [DATA_W-1:0]      mem [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] written_q;

    logic [31:0]       data_lfsr;
    logic [DATA_W-1:0] data_fill;
    logic [IDX_W-1:0]  idx;
    logic [MEM_AW-1:0] sel;
    logic              oob, is_wr, is_data, was_written;
    logic              do_resp, commit, do_fill, data_adv;
    logic [DATA_W-1:0] fill_val, base, merged;

    // mem_instr is captured only so a trace of the latched request is complete
    logic unused_trace;
    assign unused_trace = ^{instr_q, addr_q[1:0]};

    assign accept = (state_q == IDLE) && mem_valid;

`ifdef FUZZ_MEM_RAND_WAIT_EN
    logic [31:0] wait_lfsr;
    logic        unused_wait;

    fuzz_mem_lfsr #(.WIDTH(32), .SEED(~LFSR_SEED), .TAPS(LFSR_TAPS)) u_wait_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .q   (wait_lfsr)
    );

    assign wait_cnt    = CNT_W'(LATENCY) + CNT_W'(wait_lfsr[1:0]);
    assign unused_wait = ^wait_lfsr[31:2];
`else
    assign wait_cnt = CNT_W'(LATENCY);
`endif

    fuzz_mem_lfsr #(.WIDTH(32), .SEED(LFSR_SEED), .TAPS(LFSR_TAPS)) u_data_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (data_adv),
        .q   (data_lfsr)
    );

    assign idx         = addr_q[ADDR_W-1:2];
    assign sel         = idx[MEM_AW-1:0];
    assign oob         = 64'(idx) >= DEPTH_L;
    assign is_wr       = |wstrb_q;
    assign is_data     = addr_q > INSTR_LIMIT;
    assign was_written = written_q[sel];
    assign fill_val    = is_data ? data_fill : INSTR_FILL;
    assign base        = was_written ? mem[sel] : fill_val;

    // Reset is folded into the response so an aborted access leaves no trace
    assign do_resp  = (state_q == RESP) && !rst;
    assign commit   = do_resp && !oob;
    assign do_fill  = commit && !was_written;
    assign data_adv = do_fill && is_data;

    assign mem_ready  = do_resp;
    assign mem_rdata  = (commit && !is_wr) ? base : '0;
    assign fill_valid = do_fill;
    assign fill_addr  = do_fill ? idx : '0;
    assign fill_data  = do_fill ? fill_val : '0;
    assign err_oob    = do_resp && oob;

    // Wide data buses repeat the 32-bit LFSR word
    always_comb begin
        data_fill = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data_fill[i] = data_lfsr[i % 32];
        end
    end

    // Overlay the strobed write bytes on the current (or freshly filled) word
    always_comb begin
        merged = base;
        for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_q[b]) begin
                merged[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_valid) state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture and wait down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            instr_q <= 1'b0;
        end else if (accept) begin
            cnt_q   <= wait_cnt - 1'b1;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            instr_q <= mem_instr;
        end else if ((state_q == WAIT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Written bits mark words that have been materialised since reset
    always_ff @(posedge clk) begin
        if (rst) begin
            written_q <= '0;
        end else if (commit) begin
            written_q[sel] <= 1'b1;
        end
    end

    // Backing store; a read of an unwritten word stores its fill value too
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[sel] <= merged;
        end
    end

endmodule

// File: tb/tb_fuzz_mem_model.sv
module tb_fuzz_mem_model;

    localparam int DEPTH = 32768;
`ifdef FUZZ_MEM_RAND_WAIT_EN
    localparam int LAT       = 2;
    localparam bit RAND_WAIT = 1'b1;
`else
    localparam int LAT       = 1;
    localparam bit RAND_WAIT = 1'b0;
`endif
    localparam logic [31:0] SEED  = 32'hACE1_2468;
    localparam logic [31:0] ILIM  = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        fill_valid;
    logic [29:0] fill_addr;
    logic [31:0] fill_data;
    logic        err_oob;

    int checks = 0;
    int fails  = 0;
    bit run    = 1'b0;

    // reference state: words present in the map are the written ones
    logic [31:0] m_mem [int];
    logic [31:0] m_dlfsr;
    logic [31:0] m_wlfsr;

    logic        exp_ready = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic        exp_fv    = 1'b0;
    logic [29:0] exp_faddr = '0;
    logic [31:0] exp_fdata = '0;
    logic        exp_err   = 1'b0;

    fuzz_mem_model #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .err_oob    (err_oob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic model_reset();
        m_mem.delete();
        m_dlfsr = SEED;
        m_wlfsr = ~SEED;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_valid = 1'b0;
        exp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Issue one request, predict it, and capture what the DUT returned
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          output int lat, output logic [31:0] rd, output logic fv,
                          output logic [31:0] fd, output logic [29:0] fa, output logic er);
        int          w;
        int          key;
        logic [31:0] base;
        logic [31:0] mrg;
        lat = 0; rd = '0; fv = 1'b0; fd = '0; fa = '0; er = 1'b0;
        mem_valid = 1'b1;
        mem_instr = 1'($urandom);
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        @(posedge clk);
        #1;
        w = LAT;
        if (RAND_WAIT) begin
            w += int'(m_wlfsr[1:0]);
            m_wlfsr = lfsr_step(m_wlfsr);
        end
        key       = int'(a[31:2]);
        exp_err   = (key >= DEPTH);
        exp_fv    = 1'b0;
        exp_faddr = a[31:2];
        exp_fdata = '0;
        exp_rdata = '0;
        if (!exp_err) begin
            if (m_mem.exists(key)) begin
                base = m_mem[key];
            end else begin
                base = (a <= ILIM) ? 32'h0000_0013 : m_dlfsr;
                if (a > ILIM) m_dlfsr = lfsr_step(m_dlfsr);
                exp_fv    = 1'b1;
                exp_fdata = base;
            end
            mrg = base;
            for (int b = 0; b < 4; b++) if (ws[b]) mrg[8*b +: 8] = wd[8*b +: 8];
            m_mem[key] = mrg;
            exp_rdata  = (ws == 4'h0) ? base : 32'h0;
        end
        // junk on the bus while busy; the DUT must ignore it
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom);
        if ($urandom_range(0, 1) == 0) mem_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            exp_ready = (k == w);
            if (mem_ready) begin
                lat = k; rd = mem_rdata; fv = fill_valid; fd = fill_data; fa = fill_addr; er = err_oob;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(w));
        @(posedge clk);
        #1;
        exp_ready = 1'b0;
        mem_valid = 1'b0;
    endtask

    // Per-cycle comparison of DUT outputs against the reference expectations
    always @(negedge clk) begin
        if (run) begin
            if (rst) begin
                chk("rst_ready", 32'(mem_ready), 32'd0);
                chk("rst_rdata", mem_rdata, 32'd0);
                chk("rst_fill_valid", 32'(fill_valid), 32'd0);
                chk("rst_fill_addr", 32'(fill_addr), 32'd0);
                chk("rst_fill_data", fill_data, 32'd0);
                chk("rst_err_oob", 32'(err_oob), 32'd0);
            end else begin
                chk("ready", 32'(mem_ready), 32'(exp_ready));
                if (exp_ready) begin
                    chk("rdata", mem_rdata, exp_rdata);
                    chk("fill_valid", 32'(fill_valid), 32'(exp_fv));
                    chk("err_oob", 32'(err_oob), 32'(exp_err));
                    if (exp_fv) begin
                        chk("fill_addr", 32'(fill_addr), 32'(exp_faddr));
                        chk("fill_data", fill_data, exp_fdata);
                    end
                end else begin
                    chk("idle_fill_valid", 32'(fill_valid), 32'd0);
                    chk("idle_err_oob", 32'(err_oob), 32'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd, fd;
        logic [29:0] fa;
        logic        fv, er;
        logic [31:0] a;
        logic [3:0]  ws;
        rst = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        model_reset();
        @(posedge clk);
        #1;
        run = 1'b1;
        do_reset();
        repeat (2) @(posedge clk);
        #1;

        // instruction-region read of an unwritten word
        do_req(32'h0000_0010, 32'h0, 4'h0, lat, rd, fv, fd, fa, er);
        chk("pin_lat_first", 32'(lat), RAND_WAIT ? 32'd5 : 32'd1);
        chk("pin_instr_rdata", rd, 32'h0000_0013);
        chk("pin_instr_fv", 32'(fv), 32'd1);
        chk("pin_instr_faddr", 32'(fa), 32'd4);

        // data-region fill, then a re-read of the same word
        do_req(32'h0001_0000, 32'h0, 4'h0, lat, rd, fv, fd, fa, er);
        chk("pin_data_fd", fd, 32'hACE1_2468);
        chk("pin_data_rd", rd, 32'hACE1_2468);
        do_req(32'h0001_0000, 32'h0, 4'h0, lat, rd, fv, fd, fa, er);
        chk("pin_reread_rd", rd, 32'hACE1_2468);
        chk("pin_reread_fv", 32'(fv), 32'd0);

        // partial write into an unwritten data word
        do_req(32'h0001_0004, 32'hDEAD_BEEF, 4'b0101, lat, rd, fv, fd, fa, er);
        chk("pin_wr_fv", 32'(fv), 32'd1);
        chk("pin_wr_fd", fd, 32'h5670_9234);
        chk("pin_wr_rd", rd, 32'h0);
        do_req(32'h0001_0004, 32'h0, 4'h0, lat, rd, fv, fd, fa, er);
        chk("pin_merge_rd", rd, 32'h56AD_92EF);

        // out-of-range access, then word 0 still behaves
        do_req(32'(4 * DEPTH), 32'h1234_5678, 4'hF, lat, rd, fv, fd, fa, er);
        chk("pin_oob_err", 32'(er), 32'd1);
        chk("pin_oob_rd", rd, 32'h0);
        do_req(32'h0000_0000, 32'h0, 4'h0, lat, rd, fv, fd, fa, er);
        chk("pin_w0_rd", rd, 32'h0000_0013);
        chk("pin_w0_fv", 32'(fv), 32'd1);

        // reset during WAIT of a write aborts it
        mem_valid = 1'b1; mem_addr = 32'h0000_0020; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        do_req(32'h0000_0020, 32'h0, 4'h0, lat, rd, fv, fd, fa, er);
        chk("pin_abort_rd", rd, 32'h0000_0013);
        chk("pin_abort_fv", 32'(fv), 32'd1);

        // randomized traffic: reads first, then mixed reads and writes
        for (int i = 0; i < 160; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 63));
                1, 2, 3, 4: a = 32'(4 * $urandom_range(0, 31));
                default: a = 32'h0001_0000 + 32'(4 * $urandom_range(0, 31));
            endcase
            a[1:0] = 2'($urandom);
            ws = (i < 100 || $urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            do_req(a, $urandom, ws, lat, rd, fv, fd, fa, er);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
